// File: rtl/adder_pipe_ctrl_if.sv
// Valid/ready bundle for adder_pipe_ctrl: operand pairs in, sums out.
// The slave modport is the stage itself; the master modport is its producer/consumer.
interface adder_pipe_ctrl_if #(
  parameter int W = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_sum
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/adder_pipe_ctrl.sv
// Operand register + result FIFO around an external combinational adder.
// Optional build macro ADDER_CHECK_EN adds a sticky behavioural sum check on err_flag.
module adder_pipe_ctrl #(
  parameter int W     = 6,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_pipe_ctrl_if.slave  bus,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  input  logic [W:0]        add_s,
  output logic              err_flag
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          op_vld_q, op_vld_d;
  logic [W-1:0]  add_x_q, add_x_d;
  logic [W-1:0]  add_y_q, add_y_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W:0]    mem_q [DEPTH];
  logic [W:0]    mem_d [DEPTH];

  logic push, in_fire, out_fire, out_valid;

  always_comb begin
    out_valid = (count_q != '0);
    out_fire  = out_valid & bus.out_ready;
    // A full FIFO can still accept the sum when its head leaves this cycle.
    push      = op_vld_q & ((count_q < CW'(DEPTH)) | out_fire);
    in_fire   = bus.in_valid & (~op_vld_q | push);
  end

  always_comb begin
    op_vld_d = op_vld_q;
    add_x_d  = add_x_q;
    add_y_d  = add_y_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(out_fire);
    count_d  = count_q + CW'(push) - CW'(out_fire);
    mem_d    = mem_q;
    if (in_fire) begin
      op_vld_d = 1'b1;
      add_x_d  = bus.in_x;
      add_y_d  = bus.in_y;
    end else if (push) begin
      op_vld_d = 1'b0;
    end
    if (push) mem_d[wr_ptr_q] = add_s;
  end

  // Stage boundary: operand register and FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld_q <= 1'b0;
      add_x_q  <= '0;
      add_y_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      op_vld_q <= op_vld_d;
      add_x_q  <= add_x_d;
      add_y_q  <= add_y_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Stage boundary: FIFO storage (contents are masked by count, so no reset)
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign add_x         = add_x_q;
  assign add_y         = add_y_q;
  assign bus.in_ready  = ~op_vld_q | push;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef ADDER_CHECK_EN
  logic       err_q, err_d;
  logic [W:0] ref_sum;

  always_comb begin
    ref_sum = {1'b0, add_x_q} + {1'b0, add_y_q};
    err_d   = err_q | (push & (add_s != ref_sum));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

endmodule
